// File: rtl/pmod_panel_ctrl.sv
// pmod_panel_ctrl
// User-logic side of the 3-button / 5-LED PMOD panel. It turns debounced
// button levels into one-cycle press, release and long-press pulses. It
// also drives five LEDs from per-LED mode registers: off, on, a shared
// blink, or 16-level PWM.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   btns[2:0]    debounced button levels, 1 = pressed
//   btn_press    one-cycle pulse per button on press
//   btn_release  one-cycle pulse per button on release
//   btn_long     one-cycle pulse per button when the long-press threshold is reached
//   led_wr       LED config write strobe
//   led_sel      LED index 0..4 (5..7 ignored)
//   led_mode     0 = off, 1 = on, 2 = blink, 3 = pwm
//   led_duty     PWM duty in 1/16 steps
//   leds[4:0]    registered LED drive levels
module pmod_panel_ctrl #(
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter int BLINK_HALF_CYCLES = 3000000,
  parameter int PWM_PRESCALE      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btns,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release,
  output logic [2:0] btn_long,
  input  logic       led_wr,
  input  logic [2:0] led_sel,
  input  logic [1:0] led_mode,
  input  logic [3:0] led_duty,
  output logic [4:0] leds
);

  // The hold counter must be able to hold LONG_PRESS_CYCLES itself
  // because it saturates there.
  localparam int HOLD_W  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam int PRE_W   = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_FIRE  = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PWM_PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_t;

  logic [2:0]        btn_q;
  logic [HOLD_W-1:0] hold_cnt [3];
  logic [2:0]        long_done;

  led_mode_t         mode_r [5];
  logic [3:0]        duty_r [5];

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [PRE_W-1:0]   prescaler;
  logic [3:0]         pwm_cnt;

  // Button path. Each bit is independent. long_done keeps btn_long to a
  // single pulse per hold and is only cleared by a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q       <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      long_done   <= '0;
      for (int i = 0; i < 3; i++) hold_cnt[i] <= '0;
    end else begin
      btn_q       <= btns;
      btn_press   <= btns & ~btn_q;
      btn_release <= ~btns & btn_q;
      for (int i = 0; i < 3; i++) begin
        if (!btns[i]) begin
          hold_cnt[i]  <= '0;
          long_done[i] <= 1'b0;
          btn_long[i]  <= 1'b0;
        end else begin
          if (hold_cnt[i] != HOLD_MAX) hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
          if (hold_cnt[i] == HOLD_FIRE && !long_done[i]) begin
            btn_long[i]  <= 1'b1;
            long_done[i] <= 1'b1;
          end else begin
            btn_long[i]  <= 1'b0;
          end
        end
      end
    end
  end

  // LED configuration registers. Out-of-range indices are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 5; j++) begin
        mode_r[j] <= MODE_OFF;
        duty_r[j] <= '0;
      end
    end else if (led_wr && led_sel <= 3'd4) begin
      mode_r[led_sel] <= led_mode_t'(led_mode);
      duty_r[led_sel] <= led_duty;
    end
  end

  // Shared timebases. Both run freely and config writes never touch them,
  // so all blinking LEDs stay in phase with each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      prescaler   <= '0;
      pwm_cnt     <= '0;
    end else begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        pwm_cnt   <= pwm_cnt + 4'd1;
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  // LED drive levels. Duty 0 never lights because pwm_cnt is never below 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds <= '0;
    end else begin
      for (int j = 0; j < 5; j++) begin
        case (mode_r[j])
          MODE_OFF:   leds[j] <= 1'b0;
          MODE_ON:    leds[j] <= 1'b1;
          MODE_BLINK: leds[j] <= blink_phase;
          MODE_PWM:   leds[j] <= (pwm_cnt < duty_r[j]);
          default:    leds[j] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pmod_panel_ctrl.sv
// tb_pmod_panel_ctrl
// Scoreboard bench for pmod_panel_ctrl. The stimulus side predicts each
// cycle's outputs from a behavioural model and queues them. A monitor pops
// one entry per clock and compares it against the DUT.
module tb_pmod_panel_ctrl;

  localparam int LP = 8;
  localparam int BH = 4;
  localparam int PP = 1;

  logic       clk;
  logic       rst;
  logic [2:0] btns;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic [2:0] btn_long;
  logic       led_wr;
  logic [2:0] led_sel;
  logic [1:0] led_mode;
  logic [3:0] led_duty;
  logic [4:0] leds;

  pmod_panel_ctrl #(
    .LONG_PRESS_CYCLES(LP),
    .BLINK_HALF_CYCLES(BH),
    .PWM_PRESCALE(PP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btns(btns),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long),
    .led_wr(led_wr),
    .led_sel(led_sel),
    .led_mode(led_mode),
    .led_duty(led_duty),
    .leds(leds)
  );

  typedef struct packed {
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
    logic [4:0] leds;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state. k counts the clock edges since reset was released.
  int         k;
  int         run [3];
  bit         prev [3];
  logic [1:0] m_mode [5];
  logic [3:0] m_duty [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      run[i]  = 0;
      prev[i] = 1'b0;
    end
    for (int j = 0; j < 5; j++) begin
      m_mode[j] = 2'd0;
      m_duty[j] = 4'd0;
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the
  // coming edge. LED levels use the config in force before this edge and
  // the timebase values after k edges.
  task automatic applyStimulus(input logic [2:0] b, input logic wr, input logic [2:0] sel,
                               input logic [1:0] md, input logic [3:0] dt);
    exp_t e;
    int   ph;
    int   pc;
    @(negedge clk);
    btns     = b;
    led_wr   = wr;
    led_sel  = sel;
    led_mode = md;
    led_duty = dt;
    ph = (k / BH) % 2;
    pc = (k / PP) % 16;
    for (int i = 0; i < 3; i++) begin
      e.press[i] = b[i] & ~prev[i];
      e.rel[i]   = ~b[i] & prev[i];
      e.lng[i]   = b[i] && (run[i] + 1 == LP);
      run[i]     = b[i] ? run[i] + 1 : 0;
      prev[i]    = b[i];
    end
    for (int j = 0; j < 5; j++) begin
      case (m_mode[j])
        2'd0:    e.leds[j] = 1'b0;
        2'd1:    e.leds[j] = 1'b1;
        2'd2:    e.leds[j] = ph[0];
        default: e.leds[j] = (pc < int'(m_duty[j]));
      endcase
    end
    if (wr && sel <= 3'd4) begin
      m_mode[sel] = md;
      m_duty[sel] = dt;
    end
    k++;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [2:0] b, input int n);
    for (int c = 0; c < n; c++) applyStimulus(b, 1'b0, 3'd0, 2'd0, 4'd0);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_press"}, {2'b0, btn_press}, 5'd0);
    checkOutput({tag, "_release"}, {2'b0, btn_release}, 5'd0);
    checkOutput({tag, "_long"}, {2'b0, btn_long}, 5'd0);
    checkOutput({tag, "_leds"}, leds, 5'd0);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("btn_press", {2'b0, btn_press}, {2'b0, e.press});
      checkOutput("btn_release", {2'b0, btn_release}, {2'b0, e.rel});
      checkOutput("btn_long", {2'b0, btn_long}, {2'b0, e.lng});
      checkOutput("leds", leds, e.leds);
    end
  end

  initial begin
    logic [2:0] rb;
    rst      = 1'b1;
    btns     = '0;
    led_wr   = 1'b0;
    led_sel  = '0;
    led_mode = '0;
    led_duty = '0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset_state");
    releaseReset();

    // Short press on button 0.
    idle(3'b001, 3);
    idle(3'b000, 4);

    // Two long holds on button 2.
    idle(3'b100, 20);
    idle(3'b000, 3);
    idle(3'b100, 20);
    idle(3'b000, 3);

    // LED 1 on; an out-of-range write must do nothing.
    applyStimulus(3'b000, 1'b1, 3'd1, 2'd1, 4'd0);
    applyStimulus(3'b000, 1'b1, 3'd6, 2'd1, 4'd0);
    idle(3'b000, 3);

    // LED 4 blink, then forced off.
    applyStimulus(3'b000, 1'b1, 3'd4, 2'd2, 4'd0);
    idle(3'b000, 12);
    applyStimulus(3'b000, 1'b1, 3'd4, 2'd0, 4'd0);
    idle(3'b000, 3);

    // LED 0 PWM at duty 4, 0 and 15.
    applyStimulus(3'b000, 1'b1, 3'd0, 2'd3, 4'd4);
    idle(3'b000, 32);
    applyStimulus(3'b000, 1'b1, 3'd0, 2'd3, 4'd0);
    idle(3'b000, 16);
    applyStimulus(3'b000, 1'b1, 3'd0, 2'd3, 4'd15);
    idle(3'b000, 32);

    // Randomized buttons and config writes.
    rb = 3'b000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) rb = rb ^ (3'b001 << $urandom_range(0, 2));
      applyStimulus(rb,
                    ($urandom_range(0, 3) == 0),
                    3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)));
    end
    idle(3'b000, 2);

    // Asynchronous reset mid-blink with all buttons held.
    applyStimulus(3'b111, 1'b1, 3'd4, 2'd2, 4'd0);
    idle(3'b111, 6);
    @(negedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    checkAllZero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("held_rst");
    releaseReset();
    idle(3'b111, 12);
    idle(3'b000, 6);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
